// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared state encoding, control-word type and defaults for the GCD controller
package gcd_pkg;

    localparam int DEFAULT_MAX_ITER = 255;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CMP   = 3'd2,
        S_SUBP  = 3'd3,
        S_SUBQ  = 3'd4,
        S_STORE = 3'd5,
        S_DONE  = 3'd6,
        S_FAULT = 3'd7
    } gcd_state_t;

    typedef struct packed {
        logic selp;
        logic selq;
        logic sela;
        logic selb;
        logic ldp;
        logic ldq;
        logic ldr;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE  = 7'b0000000;
    localparam ctrl_t CTRL_LOAD  = 7'b1100110;
    localparam ctrl_t CTRL_SUBP  = 7'b0011100;
    localparam ctrl_t CTRL_SUBQ  = 7'b0000010;
    localparam ctrl_t CTRL_STORE = 7'b0000001;

    function automatic ctrl_t ctrl_for(input gcd_state_t s);
        case (s)
            S_LOAD:  return CTRL_LOAD;
            S_SUBP:  return CTRL_SUBP;
            S_SUBQ:  return CTRL_SUBQ;
            S_STORE: return CTRL_STORE;
            default: return CTRL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/gcd_iter_counter.sv
// rtl/gcd_iter_counter.sv - saturating subtraction counter with limit flag
module gcd_iter_counter #(
    parameter int MAX = 255,
    parameter int W   = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         limit_hit
);

    localparam logic [W-1:0] LIMIT = W'(MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && count != LIMIT) begin
            count <= count + W'(1);
        end
    end

    assign limit_hit = (count == LIMIT);

endmodule

// File: rtl/gcd_controller.sv
// rtl/gcd_controller.sv - Moore FSM sequencing the subtractive GCD datapath with an iteration limit
module gcd_controller
    import gcd_pkg::*;
#(
    parameter int MAX_ITER = DEFAULT_MAX_ITER,
    parameter int ITER_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              eq,
    input  logic              gth,
    output logic              Selp,
    output logic              Selq,
    output logic              Sela,
    output logic              Selb,
    output logic              Ldp,
    output logic              Ldq,
    output logic              Ldr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ITER_W-1:0] iter_count
);

    gcd_state_t state, state_nx;
    ctrl_t      ctrl;
    logic       limit_hit;
    logic       cnt_clr, cnt_inc;

    assign cnt_clr = (state == S_IDLE) && start;
    assign cnt_inc = (state == S_SUBP) || (state == S_SUBQ);

    gcd_iter_counter #(
        .MAX (MAX_ITER),
        .W   (ITER_W)
    ) u_iter (
        .clk       (clk),
        .rst       (rst),
        .clr       (cnt_clr),
        .inc       (cnt_inc),
        .count     (iter_count),
        .limit_hit (limit_hit)
    );

    // eq wins over the limit so (0,0) and late convergence still finish cleanly
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = start ? S_LOAD : S_IDLE;
            S_LOAD:  state_nx = S_CMP;
            S_CMP: begin
                if (eq)             state_nx = S_STORE;
                else if (limit_hit) state_nx = S_FAULT;
                else if (gth)       state_nx = S_SUBP;
                else                state_nx = S_SUBQ;
            end
            S_SUBP:  state_nx = S_CMP;
            S_SUBQ:  state_nx = S_CMP;
            S_STORE: state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            S_FAULT: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they track the state register exactly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            ctrl  <= CTRL_NONE;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            ctrl  <= ctrl_for(state_nx);
            busy  <= (state_nx != S_IDLE);
            done  <= (state_nx == S_DONE);
            err   <= (state_nx == S_FAULT);
        end
    end

    assign Selp = ctrl.selp;
    assign Selq = ctrl.selq;
    assign Sela = ctrl.sela;
    assign Selb = ctrl.selb;
    assign Ldp  = ctrl.ldp;
    assign Ldq  = ctrl.ldq;
    assign Ldr  = ctrl.ldr;

endmodule

// File: tb/tb_gcd_controller.sv
// tb/tb_gcd_controller.sv - directed bench driving gcd_controller against an 8-bit datapath model
module tb_gcd_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       eq, gth;
    logic       Selp, Selq, Sela, Selb, Ldp, Ldq, Ldr;
    logic       busy, done, err;
    logic [7:0] iter_count;
    logic [7:0] p_in = 8'd0, q_in = 8'd0;
    logic [7:0] p_reg, q_reg, r_reg, alu;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    gcd_controller dut (
        .clk(clk), .rst(rst), .start(start), .eq(eq), .gth(gth),
        .Selp(Selp), .Selq(Selq), .Sela(Sela), .Selb(Selb),
        .Ldp(Ldp), .Ldq(Ldq), .Ldr(Ldr),
        .busy(busy), .done(done), .err(err), .iter_count(iter_count)
    );

    // 8-bit subtractive datapath
    assign alu = (Sela ? p_reg : q_reg) - (Selb ? q_reg : p_reg);
    assign eq  = (p_reg == q_reg);
    assign gth = (p_reg > q_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_reg <= 8'd0;
            q_reg <= 8'd0;
            r_reg <= 8'd0;
        end else begin
            if (Ldp) p_reg <= Selp ? p_in : alu;
            if (Ldq) q_reg <= Selq ? q_in : alu;
            if (Ldr) r_reg <= p_reg;
        end
    end

    function automatic logic [7:0] ref_gcd(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Pulses start with (a,b) and counts edges after the sampling edge until done or err.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          output int lat, output int ldr_cnt, output int done_cnt,
                          output bit fin_done, output bit fin_err,
                          output logic done_next, output logic busy_next);
        @(negedge clk);
        p_in = a; q_in = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0; ldr_cnt = 0; done_cnt = 0; fin_done = 0; fin_err = 0;
        while (!fin_done && !fin_err && lat < 2000) begin
            @(negedge clk);
            lat++;
            if (Ldr)  ldr_cnt++;
            if (done) begin done_cnt++; fin_done = 1; end
            if (err)  fin_err = 1;
        end
        @(negedge clk);
        done_next = done;
        busy_next = busy;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #12;
        vectors++;
        if ({Selp, Selq, Sela, Selb, Ldp, Ldq, Ldr, busy, done, err} !== 10'b0) begin
            $display("FAIL reset_outputs: got %b want 0", {Selp, Selq, Sela, Selb, Ldp, Ldq, Ldr, busy, done, err});
            miscompares++;
        end
        vectors++;
        if (iter_count !== 8'd0) begin $display("FAIL reset_iter: got %0d want 0", iter_count); miscompares++; end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int lat, ldr_cnt, done_cnt; bit fd, fe; logic dn, bn;
        run_op(8'd12, 8'd8, lat, ldr_cnt, done_cnt, fd, fe, dn, bn);
        vectors++; if (!fd || lat !== 7) begin $display("FAIL basic_latency: got %0d (done=%0d) want 7", lat, fd); miscompares++; end
        vectors++; if (r_reg !== ref_gcd(8'd12, 8'd8) || r_reg !== 8'd4) begin $display("FAIL basic_r: got %0d want 4", r_reg); miscompares++; end
        vectors++; if (iter_count !== 8'd2) begin $display("FAIL basic_iter: got %0d want 2", iter_count); miscompares++; end
        vectors++; if (dn !== 1'b0 || bn !== 1'b0) begin $display("FAIL basic_pulse: done_next=%b busy_next=%b want 0 0", dn, bn); miscompares++; end
        repeat (3) @(negedge clk);
        vectors++; if (iter_count !== 8'd2) begin $display("FAIL basic_iter_hold: got %0d want 2", iter_count); miscompares++; end
    endtask

    task automatic test_equal;
        int lat, ldr_cnt, done_cnt; bit fd, fe; logic dn, bn;
        run_op(8'd9, 8'd9, lat, ldr_cnt, done_cnt, fd, fe, dn, bn);
        vectors++; if (!fd || lat !== 3) begin $display("FAIL equal_latency: got %0d want 3", lat); miscompares++; end
        vectors++; if (r_reg !== 8'd9) begin $display("FAIL equal_r: got %0d want 9", r_reg); miscompares++; end
        vectors++; if (iter_count !== 8'd0) begin $display("FAIL equal_iter: got %0d want 0", iter_count); miscompares++; end
    endtask

    task automatic test_long;
        int lat, ldr_cnt, done_cnt; bit fd, fe; logic dn, bn;
        run_op(8'd255, 8'd1, lat, ldr_cnt, done_cnt, fd, fe, dn, bn);
        vectors++; if (!fd || fe || lat !== 511) begin $display("FAIL long_latency: got %0d done=%0d err=%0d want 511 1 0", lat, fd, fe); miscompares++; end
        vectors++; if (r_reg !== 8'd1) begin $display("FAIL long_r: got %0d want 1", r_reg); miscompares++; end
        vectors++; if (iter_count !== 8'd254) begin $display("FAIL long_iter: got %0d want 254", iter_count); miscompares++; end
    endtask

    task automatic test_zero;
        int lat, ldr_cnt, done_cnt; bit fd, fe; logic dn, bn;
        run_op(8'd0, 8'd5, lat, ldr_cnt, done_cnt, fd, fe, dn, bn);
        vectors++; if (!fe || fd || lat !== 512) begin $display("FAIL zero_err_latency: got %0d err=%0d done=%0d want 512 1 0", lat, fe, fd); miscompares++; end
        vectors++; if (ldr_cnt !== 0) begin $display("FAIL zero_no_ldr: got %0d want 0", ldr_cnt); miscompares++; end
        vectors++; if (iter_count !== 8'd255) begin $display("FAIL zero_iter: got %0d want 255", iter_count); miscompares++; end
        vectors++; if (bn !== 1'b0 || err !== 1'b0) begin $display("FAIL zero_err_pulse: busy=%b err=%b want 0 0", bn, err); miscompares++; end
        run_op(8'd0, 8'd0, lat, ldr_cnt, done_cnt, fd, fe, dn, bn);
        vectors++; if (!fd || lat !== 3) begin $display("FAIL zero_zero_latency: got %0d want 3", lat); miscompares++; end
        vectors++; if (r_reg !== 8'd0) begin $display("FAIL zero_zero_r: got %0d want 0", r_reg); miscompares++; end
    endtask

    task automatic test_start_ignored;
        int lat; bit fd;
        @(negedge clk);
        p_in = 8'd12; q_in = 8'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0; fd = 0;
        while (!fd && lat < 100) begin
            @(negedge clk);
            lat++;
            start = (lat == 3);
            if (lat == 3) begin p_in = 8'd50; q_in = 8'd3; end
            if (done) fd = 1;
        end
        start = 1'b0;
        vectors++; if (!fd || lat !== 7) begin $display("FAIL ignore_latency: got %0d want 7", lat); miscompares++; end
        vectors++; if (r_reg !== 8'd4) begin $display("FAIL ignore_r: got %0d want 4", r_reg); miscompares++; end
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin $display("FAIL ignore_idle: busy got %b want 0", busy); miscompares++; end
    endtask

    task automatic test_reset_midrun;
        int lat, ldr_cnt, done_cnt, guard; bit fd, fe; logic dn, bn;
        @(negedge clk);
        p_in = 8'd12; q_in = 8'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (!(Ldq && !Selq) && guard < 50) begin @(negedge clk); guard++; end
        vectors++; if (guard >= 50) begin $display("FAIL midrun_reach_subq: got timeout want SUBQ"); miscompares++; end
        #1 rst = 1'b1;
        #1;
        vectors++;
        if ({Selp, Selq, Sela, Selb, Ldp, Ldq, Ldr, busy, done, err} !== 10'b0 || iter_count !== 8'd0) begin
            $display("FAIL midrun_async_reset: got %b iter=%0d want 0", {Selp, Selq, Sela, Selb, Ldp, Ldq, Ldr, busy, done, err}, iter_count);
            miscompares++;
        end
        @(negedge clk);
        rst = 1'b0;
        run_op(8'd21, 8'd14, lat, ldr_cnt, done_cnt, fd, fe, dn, bn);
        vectors++; if (!fd || lat !== 7 || r_reg !== 8'd7) begin $display("FAIL midrun_rerun: lat=%0d r=%0d want 7 7", lat, r_reg); miscompares++; end
    endtask

    task automatic test_back_to_back;
        int dones, idle_gap, cyc;
        int gaps[$];
        bit bad_r;
        @(negedge clk);
        p_in = 8'd35; q_in = 8'd15; start = 1'b1;
        dones = 0; idle_gap = 0; cyc = 0; bad_r = 0;
        while (dones < 3 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (!busy) idle_gap++;
            if (done) begin
                if (r_reg !== 8'd5) bad_r = 1;
                if (dones > 0) gaps.push_back(idle_gap);
                idle_gap = 0;
                dones++;
            end
        end
        start = 1'b0;
        vectors++; if (dones !== 3) begin $display("FAIL b2b_runs: got %0d want 3", dones); miscompares++; end
        vectors++; if (bad_r) begin $display("FAIL b2b_r: got non-5 result want 5"); miscompares++; end
        foreach (gaps[i]) begin
            vectors++;
            if (gaps[i] !== 1) begin $display("FAIL b2b_gap%0d: got %0d idle cycles want 1", i, gaps[i]); miscompares++; end
        end
        repeat (12) @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_equal;
        test_long;
        test_zero;
        test_start_ignored;
        test_reset_midrun;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
